// File: rtl/twin_reg_arb.sv
// Round-robin write arbiter owning the twin q1/q2 register pair.
// Two requesters, one committed write per two cycles, saturating contention counter.
module twin_reg_arb #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_v0,
  input  logic             req_sel0,
  input  logic [WIDTH-1:0] req_d0,
  output logic             ack0,
  input  logic             req_v1,
  input  logic             req_sel1,
  input  logic [WIDTH-1:0] req_d1,
  output logic             ack1,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic             busy,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             prio_r;
  logic             win_r;
  logic             sel_r;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] q1_r;
  logic [WIDTH-1:0] q2_r;
  logic [CNT_W-1:0] cnt_r;
  logic             any_req_s;
  logic             both_req_s;
  logic             grant_s;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state: any request in IDLE starts a one-cycle WRITE
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = any_req_s ? WRITE : IDLE;
      WRITE:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // grant selection: a lone requester wins, contention resolves to prio
  always_comb begin
    any_req_s  = req_v0 | req_v1;
    both_req_s = req_v0 & req_v1;
    if (both_req_s) begin
      grant_s = prio_r;
    end else if (req_v0) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
  end

  // datapath: capture the winner in IDLE, commit it at the end of WRITE
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r <= 1'b0;
      win_r  <= 1'b0;
      sel_r  <= 1'b0;
      data_r <= {WIDTH{1'b0}};
      q1_r   <= {WIDTH{1'b0}};
      q2_r   <= {WIDTH{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            win_r  <= grant_s;
            sel_r  <= grant_s ? req_sel1 : req_sel0;
            data_r <= grant_s ? req_d1 : req_d0;
          end
          if (both_req_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        WRITE: begin
          if (sel_r) begin
            q2_r <= data_r;
          end else begin
            q1_r <= data_r;
          end
          prio_r <= ~win_r;
        end
        default: begin
          prio_r <= 1'b0;
        end
      endcase
    end
  end

  // outputs; ack is suppressed while rst aborts the pending write
  always_comb begin
    busy         = (state_r == WRITE);
    ack0         = (state_r == WRITE) && (win_r == 1'b0) && !rst;
    ack1         = (state_r == WRITE) && (win_r == 1'b1) && !rst;
    q1           = q1_r;
    q2           = q2_r;
    conflict_cnt = cnt_r;
  end

endmodule

// File: tb/tb_twin_reg_arb.sv
// Directed self-checking bench for twin_reg_arb.
// Each step advances one rising edge, then samples outputs 1 time unit later.
module tb_twin_reg_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_v0, req_sel0, req_v1, req_sel1;
  logic [7:0] req_d0, req_d1;
  logic       ack0, ack1, busy;
  logic [7:0] q1, q2, conflict_cnt;

  int n_cmp = 0;
  int n_err = 0;

  twin_reg_arb #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_v0(req_v0), .req_sel0(req_sel0), .req_d0(req_d0), .ack0(ack0),
    .req_v1(req_v1), .req_sel1(req_sel1), .req_d1(req_d1), .ack1(ack1),
    .q1(q1), .q2(q2), .busy(busy), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_v0 = 1'b1; req_sel0 = 1'b0; req_d0 = 8'd67;
    req_v1 = 1'b0; req_sel1 = 1'b0; req_d1 = 8'd0;
    step(); step();
    chk("rst_q1", q1, 8'd0);
    chk("rst_q2", q2, 8'd0);
    chk("rst_ack0", ack0, 1'b0);
    chk("rst_ack1", ack1, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", conflict_cnt, 8'd0);

    // single write from requester 0
    rst = 1'b0;
    step();
    chk("sw_ack0", ack0, 1'b1);
    chk("sw_busy", busy, 1'b1);
    chk("sw_q1_before", q1, 8'd0);
    req_v0 = 1'b0;
    step();
    chk("sw_q1", q1, 8'd67);
    chk("sw_q2", q2, 8'd0);
    chk("sw_ack0_end", ack0, 1'b0);
    chk("sw_busy_end", busy, 1'b0);

    // contention from reset
    rst = 1'b1;
    step();
    chk("ct_rst_q1", q1, 8'd0);
    rst = 1'b0;
    req_v0 = 1'b1; req_sel0 = 1'b0; req_d0 = 8'd67;
    req_v1 = 1'b1; req_sel1 = 1'b1; req_d1 = 8'd99;
    step();
    chk("ct_ack0", ack0, 1'b1);
    chk("ct_ack1_lo", ack1, 1'b0);
    chk("ct_cnt1", conflict_cnt, 8'd1);
    req_v0 = 1'b0;
    step();
    chk("ct_q1", q1, 8'd67);
    chk("ct_idle_ack1", ack1, 1'b0);
    step();
    chk("ct_ack1", ack1, 1'b1);
    chk("ct_ack0_lo", ack0, 1'b0);
    req_v1 = 1'b0;
    step();
    chk("ct_q2", q2, 8'd99);
    chk("ct_cnt_hold", conflict_cnt, 8'd1);

    // fair alternation over 8 grants
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_v0 = 1'b1; req_sel0 = 1'b0; req_d0 = 8'h11;
    req_v1 = 1'b1; req_sel1 = 1'b1; req_d1 = 8'h22;
    for (int g = 0; g < 8; g++) begin
      step();
      chk($sformatf("fa_ack0_%0d", g), ack0, (g % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("fa_ack1_%0d", g), ack1, (g % 2 == 1) ? 1'b1 : 1'b0);
      step();
      chk($sformatf("fa_busy_%0d", g), busy, 1'b0);
    end
    chk("fa_cnt", conflict_cnt, 8'd8);
    chk("fa_q1", q1, 8'h11);
    chk("fa_q2", q2, 8'h22);

    // same target register, prio is 0 again
    req_sel0 = 1'b1; req_d0 = 8'd43;
    req_sel1 = 1'b1; req_d1 = 8'd32;
    step();
    chk("st_ack0", ack0, 1'b1);
    req_v0 = 1'b0;
    step();
    chk("st_q2_first", q2, 8'd43);
    step();
    chk("st_ack1", ack1, 1'b1);
    req_v1 = 1'b0;
    step();
    chk("st_q2_last", q2, 8'd32);
    chk("st_q1", q1, 8'h11);
    chk("st_cnt", conflict_cnt, 8'd9);

    // reset in the WRITE cycle of requester 1
    req_v1 = 1'b1; req_sel1 = 1'b0; req_d1 = 8'd32;
    step();
    chk("rm_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rm_ack1_abort", ack1, 1'b0);
    req_v1 = 1'b0;
    step();
    chk("rm_q1", q1, 8'd0);
    chk("rm_busy_idle", busy, 1'b0);
    chk("rm_ack1", ack1, 1'b0);
    rst = 1'b0;
    req_v0 = 1'b1; req_sel0 = 1'b1; req_d0 = 8'h5A;
    req_v1 = 1'b1; req_sel1 = 1'b0; req_d1 = 8'hA5;
    step();
    chk("rm_next_ack0", ack0, 1'b1);
    chk("rm_next_ack1", ack1, 1'b0);
    req_v0 = 1'b0; req_v1 = 1'b0;
    step();
    chk("rm_next_q2", q2, 8'h5A);

    // counter saturation at all-ones
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_v0 = 1'b1; req_v1 = 1'b1;
    for (int g = 0; g < 256; g++) begin
      step(); step();
    end
    chk("sat_cnt", conflict_cnt, 8'hFF);
    req_v0 = 1'b0; req_v1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
